// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Arbiter state, source-index width and wrap-around increment.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot arbiter.
// Pointer advances past the released index on each release strobe.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = src_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  input  logic         rel,
  input  logic [W-1:0] rel_idx,
  output logic [N-1:0] grant,
  output logic [W-1:0] win
);

  logic [W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (rel) begin
      ptr <= W'(next_idx(int'(rel_idx), N));
    end
  end

  always_comb begin
    int           j;
    logic [W-1:0] idx;
    logic         found;
    grant = '0;
    win   = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = W'(j);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multi-producer burst arbiter feeding one fall-through FIFO.
// Head entries carry the index of the producer that wrote them.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int  NUM_REQ   = 4,
  parameter  int  DEPTH     = 8,
  parameter  type T         = logic,
  parameter  int  MAX_BURST = 4,
  localparam int  SRC_W     = src_w(NUM_REQ),
  localparam int  CW        = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  T                   req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  output T                   out_data,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e         state, state_n;
  logic [SRC_W-1:0]   lock, lock_n, win, src;
  logic [BW-1:0]      beats, beats_n;
  logic [NUM_REQ-1:0] grant;
  logic               rel, push, pop;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count_n;
  T                   mem_data [DEPTH];
  logic [SRC_W-1:0]   mem_src  [DEPTH];

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .rel     (rel),
    .rel_idx (src),
    .grant   (grant),
    .win     (win)
  );

  assign src  = (state == BURST) ? lock : win;
  assign push = |req_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lock  <= '0;
      beats <= '0;
    end else begin
      state <= state_n;
      lock  <= lock_n;
      beats <= beats_n;
    end
  end

  always_comb begin
    state_n = state;
    lock_n  = lock;
    beats_n = beats;
    rel     = 1'b0;
    unique case (state)
      IDLE: begin
        if (push) begin
          if (req_last[win] || MAX_BURST == 1) begin
            rel = 1'b1;
          end else begin
            state_n = BURST;
            lock_n  = win;
            beats_n = BW'(1);
          end
        end
      end
      BURST: begin
        if (push) begin
          beats_n = beats + BW'(1);
          if (req_last[lock] || beats_n == BW'(MAX_BURST)) begin
            rel     = 1'b1;
            state_n = IDLE;
            beats_n = '0;
          end
        end
      end
    endcase
  end

  // Readies never look at out_ready: a full FIFO refuses even on a pop.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      unique case (state)
        IDLE:  if (!full) req_ready = grant;
        BURST: req_ready[lock] = req_valid[lock] && !full;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= req_data[src];
      mem_src[wr_ptr]  <= src;
    end
  end

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_data[rd_ptr];
  assign out_src   = mem_src[rd_ptr];

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter with integrated synchronous FIFO storage. It shares one FIFO between `NUM_REQ` producers, each using a valid/ready/last burst interface, and presents a single first-word-fall-through valid/ready output stream tagged with the source index. Bursts are held on one requester up to `MAX_BURST` beats. Occupancy is tracked by an explicit counter, so `full` and `empty` are exact on every cycle regardless of push/pop mix.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥ 2.
- `DEPTH`, default 8: FIFO entries, ≥ 2; need not be a power of 2.
- `T`, default `logic`: payload type.
- `MAX_BURST`, default 4: maximum beats per grant, ≥ 1.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  [NUM_REQ]  requester has a beat.
- `req_data`  in  T[NUM_REQ]  requester payload.
- `req_last`  in  [NUM_REQ]  beat ends the requester's burst.
- `req_ready`  out  [NUM_REQ]  beat accepted this cycle (one-hot or zero).
- `out_valid`  out  1  FIFO head valid; equals `!empty`.
- `out_data`  out  T  FIFO head payload.
- `out_src`  out  SRC_W  requester index of the head. SRC_W = max(1, $clog2(NUM_REQ)).
- `out_ready`  in  1  consumer pops the head.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- Reset values: `count` = 0, `empty` = 1, `full` = 0, `out_valid` = 0, write/read pointers = 0, state = IDLE, round-robin pointer = 0, beat counter = 0. `req_ready` is forced to 0 while `rst_n` is low.
- Push occurs when `req_valid[g] && req_ready[g]`. The entry stores {`req_data[g]`, g}.
- Pop occurs when `out_valid && out_ready`. Popping when empty is impossible by construction.
- FSM IDLE:
  - The winner is the first set `req_valid` found searching upward from the RR pointer, with wrap.
  - If `!full`, `req_ready[winner]` = 1.
  - On an accepted beat with `req_last`, or with `MAX_BURST == 1`: stay in IDLE, set RR pointer = winner+1 (mod NUM_REQ).
  - Otherwise: go to BURST with `lock` = winner and beat counter = 1.
- FSM BURST:
  - `req_ready[lock] = req_valid[lock] && !full`. All other readies are 0.
  - Each accepted beat increments the beat counter.
  - Release to IDLE on an accepted beat with `req_last`, or when the beat counter reaches `MAX_BURST`. On release, RR pointer = `lock`+1 (mod NUM_REQ).
  - If the locked requester drops valid, the lock is held. Requesters must not abandon a burst.
- `req_ready` never depends on `out_ready`. A push into a full FIFO is refused even if a pop occurs in the same cycle.
- `count` update: push only → +1; pop only → −1; both → unchanged.
- Pointer update: each pointer increments on its own event and wraps from DEPTH−1 to 0. Non-power-of-2 depths use explicit compare, not natural overflow.

## Timing
- Push to `out_valid`: 1 cycle. Data written at edge N is visible on `out_data` after edge N.
- Pop: `out_data`/`out_src` show the next entry after the popping edge. There is no read latency (fall-through).
- `full`, `empty`, `count` are registered and reflect all pushes and pops up to the last edge.
- `req_ready` is combinational from `req_valid`, FSM state, RR pointer and `full`. There is no combinational path from `out_ready`.
- Async reset mid-burst: lock and beat counter are cleared and FIFO contents are discarded (`count` = 0). The first grant after reset searches from index 0.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum `arb_state_e` {IDLE, BURST};
  - the SRC_W width function;
  - the next-index-with-wrap helper.
- Sub-module `rr_arbiter`:
  - holds the RR pointer register;
  - computes the rotated-priority one-hot grant;
  - advances the pointer on a `release` strobe carrying the released index.
- The top level holds the FSM, beat counter, storage array, pointers and occupancy counter.

## Test plan
- Fairness: all 4 requesters valid, single-beat `last`, `out_ready`=1 → grant order 0,1,2,3,0,… and `out_src` follows the same order, one cycle later.
- Burst cap: MAX_BURST=4, requester 1 sends 6 beats with no `last`, requester 2 valid → 4 beats from 1, then 2 granted, then 1 resumes.
- Full backpressure: DEPTH=8, `out_ready`=0, 10 pushes offered → 8 accepted, `full`=1, `count`=8, `req_ready`=0. Then one pop + offered push in the same cycle → push refused, `count`=7.
- Simultaneous push/pop at `count`=3 → `count` stays 3 and pointers wrap correctly across index 7→0. Repeat with DEPTH=5 for wrap 4→0.
- Lock hold: locked requester drops valid for 3 cycles while others are valid → no other grant, then its remaining beats are accepted.
- Reset mid-burst with `count`=5 → outputs at reset values immediately; after release, requester 0 is granted first.
